// File: rtl/n1_ir_buf.sv
// Instruction register with a small LIFO stash for parking/restoring IR words.
// IR load priority: forced NOP, then stash pop, then program-bus capture.
module n1_ir_buf #(
    parameter int             IW      = 16,
    parameter int             DEPTH   = 4,
    parameter logic [IW-1:0]  NOP_VAL = '0,
    parameter int             EOW_BIT = IW - 1
) (
    input  logic                       clk_i,
    input  logic                       async_rst_i,
    input  logic [IW-1:0]              pbus_dat_i,
    input  logic                       pbus_vld_i,
    output logic                       pbus_rdy_o,
    input  logic                       fc2ir_capture_i,
    input  logic                       fc2ir_stash_i,
    input  logic                       fc2ir_expend_i,
    input  logic                       fc2ir_force_nop_i,
    input  logic                       fc2ir_force_eow_i,
    input  logic                       fc2ir_flush_i,
    output logic [IW-1:0]              ir_o,
    output logic                       ir_vld_o,
    output logic                       ir_eow_o,
    output logic [IW-1:0]              stash_head_o,
    output logic [$clog2(DEPTH):0]     stash_cnt_o,
    output logic                       stash_full_o,
    output logic                       stash_empty_o,
    output logic                       stash_err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [IW-1:0] EOW_MASK = IW'(1) << EOW_BIT;

    logic [IW-1:0] ir_q, ir_nxt;
    logic          ir_vld_q, ir_vld_nxt;
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic [IW-1:0] stk [DEPTH];

    logic          empty, full;
    logic [AW-1:0] top_idx;
    logic [IW-1:0] top, push_val;
    logic          do_push, do_pop, do_swap, blocked, err_set, stk_to_ir;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign top_idx  = AW'(cnt_q - CW'(1));
    assign top      = stk[top_idx];
    // An empty IR is parked as a NOP so a later pop never resurrects garbage.
    assign push_val = ir_vld_q ? ir_q : NOP_VAL;

    assign stk_to_ir = fc2ir_expend_i & ~empty;
    assign do_swap   = fc2ir_stash_i & stk_to_ir;
    assign blocked   = fc2ir_stash_i & fc2ir_expend_i & empty;
    assign do_push   = fc2ir_stash_i & ~fc2ir_expend_i & ~full;
    assign do_pop    = fc2ir_expend_i & ~fc2ir_stash_i & ~empty;
    assign err_set   = (fc2ir_stash_i & ~fc2ir_expend_i & full)
                     | (fc2ir_expend_i & ~fc2ir_stash_i & empty);

    assign pbus_rdy_o = fc2ir_capture_i & pbus_vld_i & ~fc2ir_force_nop_i & ~stk_to_ir;

    always_comb begin
        ir_nxt     = ir_q;
        ir_vld_nxt = ir_vld_q;
        // A swap request against an empty stash freezes the IR entirely.
        if (!blocked) begin
            if (fc2ir_force_nop_i) begin
                ir_nxt     = NOP_VAL;
                ir_vld_nxt = 1'b1;
            end else if (stk_to_ir) begin
                ir_nxt     = top;
                ir_vld_nxt = 1'b1;
            end else if (fc2ir_capture_i && pbus_vld_i) begin
                ir_nxt     = pbus_dat_i;
                ir_vld_nxt = 1'b1;
            end
            if (fc2ir_force_eow_i)
                ir_nxt = ir_nxt | EOW_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            ir_q     <= NOP_VAL;
            ir_vld_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            ir_q     <= ir_nxt;
            ir_vld_q <= ir_vld_nxt;
            if (err_set)
                err_q <= 1'b1;
            if (fc2ir_flush_i)
                cnt_q <= '0;
            else if (do_push)
                cnt_q <= cnt_q + CW'(1);
            else if (do_pop)
                cnt_q <= cnt_q - CW'(1);
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk_i) begin
        if (do_push)
            stk[cnt_q[AW-1:0]] <= push_val;
        else if (do_swap)
            stk[top_idx] <= push_val;
    end

    assign ir_o          = ir_q;
    assign ir_vld_o      = ir_vld_q;
    assign ir_eow_o      = ir_q[EOW_BIT] & ir_vld_q;
    assign stash_head_o  = empty ? '0 : top;
    assign stash_cnt_o   = cnt_q;
    assign stash_full_o  = full;
    assign stash_empty_o = empty;
    assign stash_err_o   = err_q;
endmodule

// File: doc/n1_ir_buf.md
N1_IR_BUF -- requirements
Module: N1_ir_buf

Interface
REQ-001 Parameter IW, default 16, instruction width in bits (>=8).
REQ-002 Parameter DEPTH, default 4, stash entries; power of two, >=2.
REQ-003 Parameter NOP_VAL, default IW'h0000, instruction word loaded by forced NOP.
REQ-004 Parameter EOW_BIT, default IW-1, bit index of the end-of-word flag.
REQ-005 clk_i  in  1  module clock, all state on rising edge.
REQ-006 async_rst_i  in  1  asynchronous reset, active-low.
REQ-007 pbus_dat_i  in  IW  fetched instruction word.
REQ-008 pbus_vld_i  in  1  pbus_dat_i valid this cycle.
REQ-009 pbus_rdy_o  out  1  fetched word is consumed this cycle.
REQ-010 fc2ir_capture_i  in  1  load IR from program bus.
REQ-011 fc2ir_stash_i  in  1  push current IR onto stash.
REQ-012 fc2ir_expend_i  in  1  pop stash head into IR.
REQ-013 fc2ir_force_nop_i  in  1  load NOP_VAL into IR.
REQ-014 fc2ir_force_eow_i  in  1  set EOW bit of the word loaded/held in IR.
REQ-015 fc2ir_flush_i  in  1  discard all stash entries.
REQ-016 ir_o  out  IW  current instruction register.
REQ-017 ir_vld_o  out  1  IR holds a valid instruction.
REQ-018 ir_eow_o  out  1  ir_o[EOW_BIT] & ir_vld_o.
REQ-019 stash_head_o  out  IW  oldest-pushed-last (top) stash entry, zero when empty.
REQ-020 stash_cnt_o  out  clog2(DEPTH)+1  occupied stash entries.
REQ-021 stash_full_o / stash_empty_o  out  1 each  cnt==DEPTH / cnt==0.
REQ-022 stash_err_o  out  1  sticky overflow/underflow flag.

Function
REQ-023 Stash SHALL be a LIFO (stack) of DEPTH x IW; push/pop adjust a pointer, no data shifting required.
REQ-024 IR load source priority SHALL be: force_nop > expend (stash non-empty) > capture (pbus_vld_i=1); otherwise IR holds.
REQ-025 pbus_rdy_o SHALL be combinational: capture & pbus_vld_i & ~force_nop & ~(expend & ~stash_empty_o).
REQ-026 Any IR load SHALL take effect at the next edge (1-cycle latency) and set ir_vld_o=1.
REQ-027 force_eow SHALL OR the EOW bit into the word loaded that cycle, or into the held IR if no load occurs.
REQ-028 stash (not full, no expend) SHALL push the pre-edge IR; cnt+1.
REQ-029 expend (not empty, no stash) SHALL pop top into IR; cnt-1.
REQ-030 stash & expend, stash non-empty: IR <= top, top <= old IR (swap); cnt unchanged.
REQ-031 stash & expend, stash empty: IR and stash unchanged; no error.
REQ-032 stash while full without expend: push ignored, stash_err_o <= 1; IR load per REQ-024 still occurs.
REQ-033 expend while empty without stash: no pop, stash_err_o <= 1; IR loads per lower priorities.
REQ-034 flush SHALL set cnt=0 at next edge, overriding same-cycle push/pop; IR load unaffected; stash_err_o retained.
REQ-035 stash_err_o SHALL clear only on reset.
REQ-036 Stash pushes of an invalid IR (ir_vld_o=0) SHALL store NOP_VAL.

Reset
REQ-037 async_rst_i=0 SHALL immediately force: ir_o=NOP_VAL, ir_vld_o=0, cnt=0, stash_empty_o=1, stash_full_o=0, stash_err_o=0, stash_head_o=0.
REQ-038 Reset assertion mid-operation SHALL discard stash contents; deassertion is synchronous to clk_i externally.

Verification
REQ-039 Capture 16'h1234 with vld=1 -> pbus_rdy_o=1 same cycle, ir_o=16'h1234, ir_vld_o=1 next cycle.
REQ-040 IR=A; stash x4 with captures B,C,D,E -> cnt=4, full=1; 5th stash -> err=1, cnt=4; 4 expends return D,C,B,A.
REQ-041 cnt=1 top=A, IR=B; stash&expend -> IR=A, top=B, cnt=1, err=0.
REQ-042 force_nop & capture & vld -> ir_o=NOP_VAL, pbus_rdy_o=0; with force_eow -> ir_o[15]=1, ir_eow_o=1.
REQ-043 cnt=3, flush & stash same cycle -> cnt=0, empty=1; then expend -> err=1, IR unchanged.
REQ-044 cnt=2, err=1, async_rst_i low mid-cycle -> all outputs at REQ-037 values before next edge.
